// File: rtl/spi_gain_loader_if.sv
// SPI pins from the host plus the register-write port towards the gain map.
interface spi_gain_loader_if;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       we;
  logic [7:0] addr;
  logic [7:0] data_out;
  logic       busy;
  logic       frame_err;
  logic       addr_err;

  modport master (
    output sclk, cs_n, mosi,
    input  we, addr, data_out, busy, frame_err, addr_err
  );

  modport slave (
    input  sclk, cs_n, mosi,
    output we, addr, data_out, busy, frame_err, addr_err
  );
endinterface

// File: rtl/spi_gain_loader.sv
// SPI slave (mode 0, 16-bit addr/data frames) that commits range-checked
// single-cycle writes into the equalizer gain register map.
//
// state  | meaning
// ARM    | post-reset; wait for settled cs_n high so a live frame is ignored
// IDLE   | waiting for cs_n falling edge
// SHIFT  | receiving bits on sclk rising edges (busy)
// CHECK  | one cycle; validate count/address, issue write or error pulse
module spi_gain_loader #(
  parameter int NUM_REGS    = 10,
  parameter int SYNC_STAGES = 2
) (
  input logic             clk,
  input logic             rst,
  spi_gain_loader_if.slave bus
);

  localparam logic [1:0] ST_ARM   = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_CHECK = 2'd3;

  localparam logic [7:0] NUM_REGS_B = 8'(NUM_REGS);
  localparam logic [4:0] FRAME_BITS = 5'd16;
  localparam logic [4:0] CNT_SAT    = 5'd17;
  localparam logic [7:0] ARM_SETTLE = 8'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_d, cs_d;
  logic                   sclk_rise, cs_fall, cs_rise;

  logic [1:0]  state;
  logic [7:0]  arm_tmr;
  logic [4:0]  bit_cnt;
  logic [15:0] shift_reg;
  logic        we_q, frame_err_q, addr_err_q;
  logic [7:0]  addr_q, data_q;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Edge pulses are registered so pin-to-detect latency is SYNC_STAGES+1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
      sclk_rise <= 1'b0;
      cs_fall   <= 1'b0;
      cs_rise   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
      sclk_rise <= sclk_s & ~sclk_d;
      cs_fall   <= ~cs_s & cs_d;
      cs_rise   <= cs_s & ~cs_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_ARM;
      arm_tmr     <= ARM_SETTLE;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      we_q        <= 1'b0;
      frame_err_q <= 1'b0;
      addr_err_q  <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      we_q        <= 1'b0;
      frame_err_q <= 1'b0;
      addr_err_q  <= 1'b0;
      case (state)
        ST_ARM: begin
          // Synchroniser reset values are not pin values; let them flush first.
          if (arm_tmr != 8'd0)
            arm_tmr <= arm_tmr - 8'd1;
          else if (cs_s)
            state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (cs_fall) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (sclk_rise) begin
            if (bit_cnt < FRAME_BITS)
              shift_reg <= {shift_reg[14:0], mosi_s};
            if (bit_cnt != CNT_SAT)
              bit_cnt <= bit_cnt + 5'd1;
          end
          if (cs_rise)
            state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (bit_cnt != FRAME_BITS) begin
            frame_err_q <= 1'b1;
          end else if (shift_reg[15:8] < NUM_REGS_B) begin
            we_q   <= 1'b1;
            addr_q <= shift_reg[15:8];
            data_q <= shift_reg[7:0];
          end else begin
            addr_err_q <= 1'b1;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_ARM;
      endcase
    end
  end

  assign bus.we        = we_q;
  assign bus.addr      = addr_q;
  assign bus.data_out  = data_q;
  assign bus.busy      = (state == ST_SHIFT);
  assign bus.frame_err = frame_err_q;
  assign bus.addr_err  = addr_err_q;

endmodule

// File: tb/tb_spi_gain_loader.sv
// Directed and randomized SPI frames checked against a frame-level outcome model.
module tb_spi_gain_loader;

  localparam int NUM_REGS    = 10;
  localparam int SYNC_STAGES = 2;

  logic clk;
  logic rst;
  spi_gain_loader_if bus();

  spi_gain_loader #(.NUM_REGS(NUM_REGS), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Event codes: {kind, addr, data}; kind 1=write, 2=addr_err, 3=frame_err.
  logic [23:0] obs_q[$];
  logic [23:0] exp_q[$];
  int          obs_rd = 0;
  int          exp_rd = 0;
  logic [7:0]  exp_addr = 8'h00;
  logic [7:0]  exp_data = 8'h00;
  int          multi_cnt = 0;
  int          stab_cnt = 0;
  logic        prev_ok = 1'b0;
  logic [7:0]  prev_a, prev_d;

  always @(negedge clk) begin
    if (rst) begin
      if (bus.we)        obs_q.push_back({8'd1, bus.addr, bus.data_out});
      if (bus.addr_err)  obs_q.push_back({8'd2, 8'd0, 8'd0});
      if (bus.frame_err) obs_q.push_back({8'd3, 8'd0, 8'd0});
      if ((32'(bus.we) + 32'(bus.addr_err) + 32'(bus.frame_err)) > 1) multi_cnt++;
      if (prev_ok && !bus.we && ((bus.addr != prev_a) || (bus.data_out != prev_d))) stab_cnt++;
      prev_ok = 1'b1;
    end else begin
      prev_ok = 1'b0;
    end
    prev_a = bus.addr;
    prev_d = bus.data_out;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_frame(input logic [15:0] word, input int nbits);
    logic [7:0] a;
    logic [7:0] d;
    a = word[15:8];
    d = word[7:0];
    if (nbits != 16) begin
      exp_q.push_back({8'd3, 8'd0, 8'd0});
    end else if (int'(a) < NUM_REGS) begin
      exp_q.push_back({8'd1, a, d});
      exp_addr = a;
      exp_data = d;
    end else begin
      exp_q.push_back({8'd2, 8'd0, 8'd0});
    end
  endtask

  task automatic cs_low();
    @(negedge clk);
    bus.cs_n = 1'b0;
  endtask

  task automatic cs_high(input int half);
    repeat (half) @(negedge clk);
    bus.cs_n = 1'b1;
  endtask

  // frame[16] is the first bit on the wire.
  task automatic send_bits(input logic [16:0] frame, input int first, input int last, input int half);
    for (int i = first; i < last; i++) begin
      @(negedge clk);
      bus.mosi = frame[16-i];
      repeat (half) @(negedge clk);
      bus.sclk = 1'b1;
      repeat (half) @(negedge clk);
      bus.sclk = 1'b0;
    end
  endtask

  task automatic run_frame(input logic [15:0] word, input int nbits, input int half, input int gap);
    logic [16:0] frame;
    frame = {word, 1'($urandom)};
    repeat (gap) @(negedge clk);
    cs_low();
    if (nbits > 0) begin
      send_bits(frame, 0, 1, half);
      check("busy_in_frame", 32'(bus.busy), 32'd1);
      send_bits(frame, 1, nbits, half);
    end
    cs_high(half);
    model_frame(word, nbits);
  endtask

  task automatic check_events(input string tag);
    int n_obs;
    int n_exp;
    repeat (10) @(negedge clk);
    n_obs = obs_q.size() - obs_rd;
    n_exp = exp_q.size() - exp_rd;
    check({tag, "_count"}, 32'(n_obs), 32'(n_exp));
    for (int i = 0; i < n_exp && i < n_obs; i++)
      check({tag, "_event"}, 32'(obs_q[obs_rd+i]), 32'(exp_q[exp_rd+i]));
    obs_rd = obs_q.size();
    exp_rd = exp_q.size();
    check({tag, "_addr"}, 32'(bus.addr), 32'(exp_addr));
    check({tag, "_data"}, 32'(bus.data_out), 32'(exp_data));
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int nbits_tbl[6];
    logic [15:0] w;
    nbits_tbl = '{0, 15, 16, 16, 16, 17};
    rst      = 1'b0;
    bus.sclk = 1'b0;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_we", 32'(bus.we), 32'd0);
    check("rst_addr", 32'(bus.addr), 32'd0);
    check("rst_data", 32'(bus.data_out), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_errs", 32'({bus.frame_err, bus.addr_err}), 32'd0);
    @(posedge clk); #2 rst = 1'b1;
    repeat (8) @(negedge clk);

    run_frame(16'h035A, 16, 4, 4);
    check_events("valid");

    run_frame(16'h00FF, 16, 4, 6);
    check_events("bound_lo");
    run_frame(16'h0901, 16, 5, 6);
    check_events("bound_hi");
    run_frame(16'h0A77, 16, 4, 6);
    check_events("addr_oor");

    run_frame(16'h1234, 15, 4, 6);
    run_frame(16'h0356, 17, 4, 6);
    run_frame(16'h0000, 0, 4, 6);
    check_events("short_long_zero");
    run_frame(16'h0512, 16, 4, 6);
    check_events("after_err");

    // Reset in the middle of a frame; the tail must be ignored.
    repeat (4) @(negedge clk);
    cs_low();
    send_bits({16'h0633, 1'b0}, 0, 8, 4);
    @(posedge clk); #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_we", 32'(bus.we), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_addr", 32'(bus.addr), 32'd0);
    check("midrst_data", 32'(bus.data_out), 32'd0);
    @(posedge clk); #2 rst = 1'b1;
    exp_addr = 8'h00;
    exp_data = 8'h00;
    send_bits({16'h0633, 1'b0}, 8, 16, 4);
    cs_high(4);
    check_events("midrst");
    run_frame(16'h0180, 16, 4, 6);
    check_events("post_rst");

    run_frame(16'h0211, 16, 4, 6);
    run_frame(16'h0422, 16, 4, 3);
    check_events("back2back");

    // Commit latency at minimum sclk phases.
    repeat (6) @(negedge clk);
    cs_low();
    send_bits({16'h07A5, 1'b0}, 0, 16, 4);
    repeat (4) @(negedge clk);
    bus.cs_n = 1'b1;
    model_frame(16'h07A5, 16);
    repeat (SYNC_STAGES + 2) @(posedge clk);
    #1 check("lat_early_we", 32'(bus.we), 32'd0);
    @(posedge clk);
    #1 check("lat_we", 32'(bus.we), 32'd1);
    check_events("min_phase");

    for (int k = 0; k < 10; k++) begin
      w = 16'($urandom);
      w[15:8] = 8'($urandom_range(0, 13));
      run_frame(w, nbits_tbl[$urandom_range(0, 5)], $urandom_range(4, 6), $urandom_range(3, 8));
      check_events("random");
    end

    check("exclusive_pulses", 32'(multi_cnt), 32'd0);
    check("addr_data_stable", 32'(stab_cnt), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
